extmem_responder: RTL and testbench

- Memory-side responder for the external-memory interface used by the layer controller.
- The controller issues reads on re/rd_addr (buffer load) and writes on we/wr_addr/wr_data (buffer save); this block services both.
- Synthesizable SRAM-backed model with programmable read latency, out-of-range detection and access counters. Used as the on-chip stand-in for external DRAM in FPGA builds and system simulation.

---
 rtl/extmem_responder_if.sv | 27 ++
 rtl/extmem_responder.sv | 111 +++++++++++
 tb/tb_extmem_responder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/extmem_responder_if.sv
// External-memory bus between the layer controller (master) and the memory responder (slave).
// It carries the read/write strobes, the read response and the status/counter outputs.
interface extmem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 32
);
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              re;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              oob_err;
    logic [31:0]       rd_cnt;
    logic [31:0]       wr_cnt;

    modport master (
        output we, wr_addr, wr_data, re, rd_addr,
        input  rd_data, rd_valid, oob_err, rd_cnt, wr_cnt
    );

    modport slave (
        input  we, wr_addr, wr_data, re, rd_addr,
        output rd_data, rd_valid, oob_err, rd_cnt, wr_cnt
    );
endinterface

// File: rtl/extmem_responder.sv
// SRAM-backed stand-in for external DRAM: write-first array, RD_LAT-deep read pipeline,
// sticky out-of-range flag and saturating access counters.
module extmem_responder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4096,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    extmem_responder_if.slave  bus
);
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("extmem_responder: RD_LAT must be within 1..4");
    end

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              wr_ok;
    logic              rd_ok;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_word_p0;

    logic [DATA_W-1:0] data_q [RD_LAT];
    logic [RD_LAT-1:0] vld_q;

    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic        oob_q, oob_d;

    // Full-width compare first; only in-range addresses are ever used to index the array.
    assign wr_ok  = {1'b0, bus.wr_addr} < DEPTH_A;
    assign rd_ok  = {1'b0, bus.rd_addr} < DEPTH_A;
    assign wr_idx = bus.wr_addr[IDX_W-1:0];
    assign rd_idx = bus.rd_addr[IDX_W-1:0];

    // Stage 0: array sample with write-first bypass; out-of-range reads return zero.
    always_comb begin
        rd_word_p0 = '0;
        if (rd_ok) begin
            if (bus.we && wr_ok && (bus.wr_addr == bus.rd_addr)) begin
                rd_word_p0 = bus.wr_data;
            end else begin
                rd_word_p0 = mem_q[rd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && bus.we && wr_ok) begin
            mem_q[wr_idx] <= bus.wr_data;
        end
    end

    // Stages 0..RD_LAT-1: data only advances with a valid, so the last stage holds its response.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q              <= '0;
            data_q[RD_LAT-1]   <= '0;
        end else begin
            vld_q[0] <= bus.re;
            if (bus.re) begin
                data_q[0] <= rd_word_p0;
            end
            for (int s = 1; s < RD_LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) begin
                    data_q[s] <= data_q[s-1];
                end
            end
        end
    end

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        oob_d    = oob_q | (bus.we && !wr_ok) | (bus.re && !rd_ok);
        if (bus.re) begin
            rd_cnt_d = sat_inc(rd_cnt_q);
        end
        if (bus.we) begin
            wr_cnt_d = sat_inc(wr_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            oob_q    <= 1'b0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            oob_q    <= oob_d;
        end
    end

    assign bus.rd_data  = data_q[RD_LAT-1];
    assign bus.rd_valid = vld_q[RD_LAT-1];
    assign bus.oob_err  = oob_q;
    assign bus.rd_cnt   = rd_cnt_q;
    assign bus.wr_cnt   = wr_cnt_q;
endmodule

// File: tb/tb_extmem_responder.sv
// Directed bench for extmem_responder: one instance at RD_LAT=1 and one at RD_LAT=3,
// with hand-computed expected values.
module tb_extmem_responder;
    logic clk = 1'b0;
    logic rst1, rst3;
    int   n_vec = 0;
    int   n_err = 0;
    logic [15:0] buf_q [64];

    always #5 clk = ~clk;

    extmem_responder_if #(.DATA_W(16), .ADDR_W(32)) b1 ();
    extmem_responder_if #(.DATA_W(16), .ADDR_W(32)) b3 ();

    extmem_responder #(.DATA_W(16), .ADDR_W(32), .DEPTH(4096), .RD_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (b1)
    );

    extmem_responder #(.DATA_W(16), .ADDR_W(32), .DEPTH(4096), .RD_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (b3)
    );

    function automatic logic [15:0] src(input int i);
        return 16'hC000 ^ (16'(i) * 16'h0111);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic w1(input logic [31:0] a, input logic [15:0] d);
        b1.we = 1'b1; b1.wr_addr = a; b1.wr_data = d;
        tick();
        b1.we = 1'b0;
    endtask

    task automatic r1(input logic [31:0] a);
        b1.re = 1'b1; b1.rd_addr = a;
        tick();
        b1.re = 1'b0;
    endtask

    task automatic w3(input logic [31:0] a, input logic [15:0] d);
        b3.we = 1'b1; b3.wr_addr = a; b3.wr_data = d;
        tick();
        b3.we = 1'b0;
    endtask

    initial begin
        b1.we = 1'b0; b1.wr_addr = '0; b1.wr_data = '0; b1.re = 1'b0; b1.rd_addr = '0;
        b3.we = 1'b0; b3.wr_addr = '0; b3.wr_data = '0; b3.re = 1'b0; b3.rd_addr = '0;
        rst1 = 1'b1; rst3 = 1'b1;
        b1.re = 1'b1; b1.we = 1'b1; b1.wr_addr = 32'd5000;
        tick(); tick();
        chk("rst1_valid", b1.rd_valid, 0);
        chk("rst1_data",  b1.rd_data,  0);
        chk("rst1_oob",   b1.oob_err,  0);
        chk("rst1_rdcnt", b1.rd_cnt,   0);
        chk("rst1_wrcnt", b1.wr_cnt,   0);
        chk("rst3_valid", b3.rd_valid, 0);
        chk("rst3_data",  b3.rd_data,  0);
        b1.re = 1'b0; b1.we = 1'b0;
        rst1 = 1'b0; rst3 = 1'b0;

        // Basic RD_LAT=1 reads
        w1(5, 16'h1234);
        w1(6, 16'hBEEF);
        b1.re = 1'b1; b1.rd_addr = 5;
        tick();
        chk("basic_v0", b1.rd_valid, 1);
        chk("basic_d0", b1.rd_data, 16'h1234);
        b1.rd_addr = 6;
        tick();
        chk("basic_v1", b1.rd_valid, 1);
        chk("basic_d1", b1.rd_data, 16'hBEEF);
        b1.re = 1'b0;
        tick();
        chk("basic_idle_v", b1.rd_valid, 0);
        chk("basic_hold_d", b1.rd_data, 16'hBEEF);
        chk("basic_rdcnt", b1.rd_cnt, 2);
        chk("basic_wrcnt", b1.wr_cnt, 2);
        chk("basic_oob", b1.oob_err, 0);

        // Same-cycle write/read to one address
        w1(10, 16'h0001);
        b1.we = 1'b1; b1.wr_addr = 10; b1.wr_data = 16'hA5A5;
        b1.re = 1'b1; b1.rd_addr = 10;
        tick();
        b1.we = 1'b0; b1.re = 1'b0;
        chk("coll_v", b1.rd_valid, 1);
        chk("coll_d", b1.rd_data, 16'hA5A5);

        // Out-of-range accesses
        w1(0, 16'h7777);
        r1(4096);
        chk("oobrd_v", b1.rd_valid, 1);
        chk("oobrd_d", b1.rd_data, 0);
        chk("oobrd_flag", b1.oob_err, 1);
        w1(32'h0001_0000, 16'hFFFF);
        r1(0);
        chk("oobwr_mem0", b1.rd_data, 16'h7777);
        chk("oobwr_flag", b1.oob_err, 1);
        chk("oob_rdcnt", b1.rd_cnt, 5);
        chk("oob_wrcnt", b1.wr_cnt, 6);

        // Streaming: preload source, reset, then 64-word load and 64-word save
        for (int i = 0; i < 64; i++) w1(100 + i, src(i));
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        chk("stream_oob_clr", b1.oob_err, 0);
        for (int i = 0; i < 64; i++) begin
            b1.re = 1'b1; b1.rd_addr = 100 + i;
            tick();
            buf_q[i] = b1.rd_data;
        end
        b1.re = 1'b0;
        for (int i = 0; i < 64; i++) w1(1000 + i, buf_q[i]);
        chk("stream_wrcnt", b1.wr_cnt, 64);
        chk("stream_rdcnt", b1.rd_cnt, 64);
        for (int i = 0; i < 64; i++) begin
            r1(1000 + i);
            chk($sformatf("stream_w%0d", i), b1.rd_data, src(i));
        end

        // RD_LAT=3 latency sweep
        for (int i = 0; i < 8; i++) w3(i, 16'h0100 + 16'(i));
        for (int k = 0; k < 12; k++) begin
            b3.re = (k < 8); b3.rd_addr = k;
            tick();
            chk($sformatf("lat3_v%0d", k), b3.rd_valid, (k >= 2 && k <= 9));
            chk($sformatf("lat3_d%0d", k), b3.rd_data,
                (k < 2) ? 64'h0 : (k <= 9) ? 64'h100 + 64'(k - 2) : 64'h107);
        end
        b3.re = 1'b0;

        // Write after an in-flight read does not alter its response
        b3.re = 1'b1; b3.rd_addr = 3;
        tick();
        b3.re = 1'b0;
        chk("war_v0", b3.rd_valid, 0);
        w3(3, 16'hCAFE);
        tick();
        chk("war_v", b3.rd_valid, 1);
        chk("war_d", b3.rd_data, 16'h0103);
        tick();

        // Reset in the middle of a read stream
        for (int a = 0; a < 3; a++) begin
            b3.re = 1'b1; b3.rd_addr = a;
            tick();
        end
        chk("mid_pre_v", b3.rd_valid, 1);
        chk("mid_pre_d", b3.rd_data, 16'h0100);
        b3.re = 1'b0;
        rst3 = 1'b1;
        b3.we = 1'b1; b3.wr_addr = 0; b3.wr_data = 16'hDEAD;
        tick();
        chk("mid_rst_v", b3.rd_valid, 0);
        chk("mid_rst_rdcnt", b3.rd_cnt, 0);
        chk("mid_rst_wrcnt", b3.wr_cnt, 0);
        chk("mid_rst_d", b3.rd_data, 0);
        rst3 = 1'b0; b3.we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("mid_quiet_v%0d", k), b3.rd_valid, 0);
        end
        for (int k = 0; k < 5; k++) begin
            b3.re = (k < 3); b3.rd_addr = k;
            tick();
            chk($sformatf("mid_rb_v%0d", k), b3.rd_valid, (k >= 2));
            chk($sformatf("mid_rb_d%0d", k), b3.rd_data, (k < 2) ? 64'h0 : 64'h100 + 64'(k - 2));
        end
        b3.re = 1'b0;
        chk("mid_rb_rdcnt", b3.rd_cnt, 3);
        chk("mid_rb_wrcnt", b3.wr_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
